time_display_scanner: RTL and testbench

TIME_DISPLAY_SCANNER -- requirements
Module: time_display_scanner

---
 rtl/time_display_scanner_pkg.sv | 33 +++
 rtl/time_display_scanner_bcd_to_seg.sv | 28 ++
 rtl/time_display_scanner.sv | 159 +++++++++++++++
 tb/tb_time_display_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/time_display_scanner_pkg.sv
// Shared constants for the six-digit time display scanner: active-low
// segment patterns and the blink field selector encoding.
package time_display_scanner_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Which two-digit field blinks
    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_SEC  = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_HOUR = 2'd3
    } blink_sel_e;

    // Per-slot phase: anodes off for ghosting suppression, then digit on
    typedef enum logic {
        SLOT_DEAD = 1'b0,
        SLOT_ON   = 1'b1
    } slot_state_e;

endpackage

// File: rtl/time_display_scanner_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal
// codes show a dash so a corrupted counter is visible on the display.
module bcd_to_seg
    import time_display_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup with dash fallback
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scanner.sv
// Multiplexed six-digit HH:MM:SS display scanner with per-frame snapshot,
// anode dead time, field blinking, leading-zero blanking and colon dots.
//
// state     | meaning
// SLOT_DEAD | first DEAD_CYCLES of a slot, all anodes off
// SLOT_ON   | anode of the current slot driven unless suppressed
module time_display_scanner
    import time_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] secLSB,
    input  logic [3:0] secMSB,
    input  logic [3:0] minLSB,
    input  logic [3:0] minMSB,
    input  logic [3:0] hourLSB,
    input  logic [3:0] hourMSB,
    input  logic [1:0] blink_sel,
    input  logic       lzb_en,
    input  logic       colon_en,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM  = CW'(DEAD_CYCLES);
    localparam logic [BW-1:0] BLINK_LIM = BW'(BLINK_FRAMES);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [3:0]    snap [6];
    logic          blink_on;
    logic [BW-1:0] bcnt;
    slot_state_e   state, state_nxt;
    logic          frame_hit;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic          field_hit, suppress;
    blink_sel_e    bsel;
    logic [5:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign frame_hit = (idx == 3'd0) && (cnt == '0);
    assign bsel      = blink_sel_e'(blink_sel);

    // Prescaler and slot index advance; slot phase follows the next count
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
        if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        state_nxt = (cnt_nxt < DEAD_LIM) ? SLOT_DEAD : SLOT_ON;
    end

    // Scan position and slot phase registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= 3'd0;
            state <= (DEAD_CYCLES > 0) ? SLOT_DEAD : SLOT_ON;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
        end
    end

    // Digit snapshot and blink phase, both updated only on frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) snap[i] <= 4'd0;
            blink_on <= 1'b1;
            bcnt     <= '0;
        end else if (frame_hit) begin
            snap[0] <= secLSB;
            snap[1] <= secMSB;
            snap[2] <= minLSB;
            snap[3] <= minMSB;
            snap[4] <= hourLSB;
            snap[5] <= hourMSB;
            if (bcnt == BLINK_LIM) begin
                blink_on <= ~blink_on;
                bcnt     <= BW'(1);
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Select the snapshot digit for the current slot
    always_comb begin
        cur_digit = snap[0];
        case (idx)
            3'd1: cur_digit = snap[1];
            3'd2: cur_digit = snap[2];
            3'd3: cur_digit = snap[3];
            3'd4: cur_digit = snap[4];
            3'd5: cur_digit = snap[5];
            default: cur_digit = snap[0];
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Blink field membership and leading-zero blanking
    always_comb begin
        field_hit = 1'b0;
        case (bsel)
            BLINK_SEC:  field_hit = (idx <= 3'd1);
            BLINK_MIN:  field_hit = (idx == 3'd2) || (idx == 3'd3);
            BLINK_HOUR: field_hit = (idx >= 3'd4);
            default:    field_hit = 1'b0;
        endcase
        suppress = (field_hit && !blink_on) ||
                   ((idx == 3'd5) && lzb_en && (snap[5] == 4'd0));
    end

    // Slot output decode; everything dark unless ON and not suppressed
    always_comb begin
        an_nxt  = 6'h3F;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (state == SLOT_ON && !suppress) begin
            an_nxt  = ~(6'h01 << idx);
            seg_nxt = dec_seg;
            dp_nxt  = !(colon_en && ((idx == 3'd2) || (idx == 3'd4)));
        end
    end

    // Registered outputs, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= 6'h3F;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_hit;
        end
    end

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner with small scan parameters.
module tb_time_display_scanner;

    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = RD * 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d [6];
    logic [1:0] blink_sel;
    logic       lzb_en, colon_en;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp, frame_start;

    int errors = 0;
    int checks = 0;
    int oc = 0;

    logic [6:0] segtab [16];
    logic [3:0] msnap [6];

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg_exp;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    time_display_scanner #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .secLSB     (d[0]),
        .secMSB     (d[1]),
        .minLSB     (d[2]),
        .minMSB     (d[3]),
        .hourLSB    (d[4]),
        .hourMSB    (d[5]),
        .blink_sel  (blink_sel),
        .lzb_en     (lzb_en),
        .colon_en   (colon_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (out cycle %0d)", name, act, exp, oc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        oc++;
    endtask

    // After return, the DUT is in scan cycle 0; next tick shows its outputs
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        oc = 0;
    endtask

    task automatic run_to(input int n);
        while (oc < n) tick();
    endtask

    // Expected {an,seg,dp,frame_start} produced from scan cycle t
    function automatic logic [14:0] expect_out(input int t);
        int slot, c, k;
        bit on, sup, fs;
        logic [5:0] a;
        slot = (t / RD) % 6;
        c    = t % RD;
        k    = t / FRAME;
        on   = ((k / BF) % 2) == 0;
        fs   = (t % FRAME) == 0;
        if (c < DC) return {6'h3F, 7'h7F, 1'b1, fs};
        sup = (blink_sel != 2'd0 && (slot / 2) == (int'(blink_sel) - 1) && !on) ||
              (slot == 5 && lzb_en && msnap[5] == 4'd0);
        if (sup) return {6'h3F, 7'h7F, 1'b1, 1'b0};
        a = 6'h3F;
        a[slot] = 1'b0;
        return {a, segtab[msnap[slot]], !(colon_en && (slot == 2 || slot == 4)), 1'b0};
    endfunction

    initial begin
        segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 16; i++) begin
            tbl[i].digit   = 4'(i);
            tbl[i].seg_exp = segtab[i];
        end

        d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        blink_sel = 2'd0;
        lzb_en    = 1'b0;
        colon_en  = 1'b0;

        // Reset values
        reset = 1'b1;
        tick(); tick(); tick();
        chk("reset_an", an, 6'h3F);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_fs", frame_start, 1'b0);

        // Decoder table through slot 0
        for (int i = 0; i < 16; i++) begin
            d[0] = tbl[i].digit;
            do_reset();
            run_to(3);
            chk("tbl_an", an, 6'h3E);
            chk("tbl_seg", seg, tbl[i].seg_exp);
        end

        // First frame timing and snapshot tearing protection
        d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        do_reset();
        tick();
        chk("first_fs", frame_start, 1'b1);
        chk("dead1_an", an, 6'h3F);
        tick();
        chk("fs_pulse_end", frame_start, 1'b0);
        chk("dead2_an", an, 6'h3F);
        tick();
        chk("slot0_an", an, 6'h3E);
        chk("slot0_seg", seg, 7'h79);
        d[0] = 4'd7;
        run_to(8);
        chk("slot0_end_an", an, 6'h3E);
        chk("slot0_hold_seg", seg, 7'h79);
        tick();
        chk("slot1_dead_an", an, 6'h3F);
        run_to(11);
        chk("slot1_an", an, 6'h3D);
        chk("slot1_seg", seg, 7'h24);
        run_to(48);
        chk("fs_before_period", frame_start, 1'b0);
        tick();
        chk("fs_period", frame_start, 1'b1);
        run_to(51);
        chk("new_snap_seg", seg, 7'h78);

        // Reset in slot 3 cycle 5
        do_reset();
        run_to(29);
        chk("pre_abort_an", an, 6'h37);
        reset = 1'b1;
        tick();
        chk("abort_an", an, 6'h3F);
        chk("abort_seg", seg, 7'h7F);
        chk("abort_fs", frame_start, 1'b0);
        reset = 1'b0;
        oc = 0;
        tick();
        chk("restart_fs", frame_start, 1'b1);
        run_to(3);
        chk("restart_an", an, 6'h3E);

        // Minutes field blinks two frames on, two off
        blink_sel = 2'd2;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_to(k * FRAME + 21);
            chk("blink_min", an, ((k / 2) % 2 == 0) ? 6'h3B : 6'h3F);
            run_to(k * FRAME + 11);
        end

        // Randomized run against the reference model
        d = '{4'd3, 4'hC, 4'd9, 4'd5, 4'd2, 4'd0};
        blink_sel = 2'd2;
        lzb_en    = 1'b1;
        colon_en  = 1'b1;
        do_reset();
        for (int t = 0; t < FRAME * 14; t++) begin
            if (t > 0) begin
                for (int i = 0; i < 5; i++)
                    if ($urandom_range(0, 15) == 0) d[i] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) d[5] = 4'($urandom_range(0, 2));
                if ($urandom_range(0, 59) == 0) blink_sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) lzb_en = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 59) == 0) colon_en = 1'($urandom_range(0, 1));
            end
            if (t % FRAME == 0) msnap = d;
            begin
                logic [14:0] exp_v;
                exp_v = expect_out(t);
                tick();
                chk("rand", {17'd0, an, seg, dp, frame_start}, {17'd0, exp_v});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
